// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial pattern transmitter; detector benches import
// this package so they decode the debug state bus the same way.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_GAP   = 3'd2
  } tx_state_e;

  localparam int unsigned LEN_W = 4;
  localparam int unsigned GAP_W = 4;

  // Zero or oversize requests both mean "send the whole payload".
  function automatic int unsigned eff_len(input logic [LEN_W-1:0] len,
                                          input int unsigned data_w);
    int unsigned l;
    l = 32'(len);
    return (l == 0 || l > data_w) ? data_w : l;
  endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Parallel-load, MSB-out, left-shifting payload register; zeros fill from the LSB.
module tx_shift_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_val,
  output logic              msb_out
);

  logic [DATA_W-1:0] sr_q, sr_d;

  // NOTE: sr_d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift) begin
      sr_d = sr_q << 1;
    end
  end

  // NOTE: non-blocking here so every flop samples pre-edge values regardless of block ordering.
  // NOTE: this is a plain register, not a RAM, so it is reset with everything else and never shows X.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_out = sr_q[DATA_W-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Frames a DATA_W-bit payload MSB-first onto a serial line, one bit per clock,
// followed by GAP_CYC idle cycles. All outputs are registered.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        len,
  output logic              ready,
  output logic              serial_out,
  output logic              serial_valid,
  output logic              done,
  output logic [2:0]        state
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              ready_q, ready_d;
  logic              out_q, out_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  len_eff;
  logic [DATA_W-1:0] aligned;
  logic              sr_load, sr_shift, sr_msb;

  // The first bit leaves straight from the aligned input, so the register is
  // loaded pre-shifted and its MSB is always the next bit still to send.
  tx_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load),
    .shift    (sr_shift),
    .load_val (aligned << 1),
    .msb_out  (sr_msb)
  );

  always_comb begin
    len_eff  = CNT_W'(eff_len(len, DATA_W));
    aligned  = data << (DATA_W - 32'(len_eff));
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    ready_d  = 1'b0;
    out_d    = 1'b0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          state_d = ST_SHIFT;
          ready_d = 1'b0;
          cnt_d   = len_eff;
          sr_load = 1'b1;
          out_d   = aligned[DATA_W-1];
          valid_d = 1'b1;
          done_d  = (len_eff == CNT_W'(1));
        end
      end

      // cnt_q counts bits still on the line, including the one currently driven.
      ST_SHIFT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          gap_d   = GAP_W'(GAP_CYC);
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          sr_shift = 1'b1;
          out_d    = sr_msb;
          valid_d  = 1'b1;
          done_d   = (cnt_q == CNT_W'(2));
        end
      end

      ST_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          state_d = ST_IDLE;
          gap_d   = '0;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b1;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign state        = state_q;
  assign ready        = ready_q;
  assign serial_out   = out_q;
  assign serial_valid = valid_q;
  assign done         = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: vector table of frames, burst start,
// mid-frame reset, and a "101" Mealy detector fed from serial_out.
module tb_serial_pattern_tx;
  import serial_tx_pkg::*;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned GAP_CYC = 2;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] data;
  logic [3:0] len;
  logic       ready, serial_out, serial_valid, done;
  logic [2:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.DATA_W(DATA_W), .GAP_CYC(GAP_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .data         (data),
    .len          (len),
    .ready        (ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .done         (done),
    .state        (state)
  );

  // Overlapping "101" Mealy detector driven by the transmitter's line.
  typedef enum logic [1:0] {D0, D1, D2} det_e;
  det_e det_st;
  logic det_out;
  always_ff @(posedge clk) begin
    if (rst) det_st <= D0;
    else begin
      case (det_st)
        D0:      det_st <= serial_out ? D1 : D0;
        D1:      det_st <= serial_out ? D1 : D2;
        default: det_st <= serial_out ? D1 : D0;
      endcase
    end
  end
  assign det_out = (det_st == D2) && serial_out;

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    int         exp_len;
    logic [7:0] exp_pat;
  } vec_t;

  vec_t       vecs [7];
  logic [1:0] hist;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] pk(input logic [2:0] st, input logic r, input logic v,
                                    input logic o, input logic d);
    return {st, r, v, o, d};
  endfunction

  function automatic logic [6:0] obs();
    return {state, ready, serial_valid, serial_out, done};
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 50 && ready !== 1'b1; i++) @(negedge clk);
    check("ready_wait", 32'(ready), 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    wait_ready();
    data  = v.data;
    len   = v.len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < v.exp_len; k++) begin
      check($sformatf("v%0d_bit%0d", idx, k), 32'(obs()),
            32'(pk(ST_SHIFT, 1'b0, 1'b1, v.exp_pat[v.exp_len-1-k], k == v.exp_len - 1)));
      @(negedge clk);
    end
    for (int g = 0; g < int'(GAP_CYC); g++) begin
      check($sformatf("v%0d_gap%0d", idx, g), 32'(obs()), 32'(pk(ST_GAP, 1'b0, 1'b0, 1'b0, 1'b0)));
      @(negedge clk);
    end
    check($sformatf("v%0d_idle", idx), 32'(obs()), 32'(pk(ST_IDLE, 1'b1, 1'b0, 1'b0, 1'b0)));
  endtask

  task automatic step(input logic b);
    logic exp_det;
    exp_det = (hist == 2'b10) && b;
    check("lb_out", 32'(serial_out), 32'(b));
    check("lb_det", 32'(det_out), 32'(exp_det));
    hist = {hist[0], b};
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int starts[$];
    logic [2:0] prev;
    logic [7:0] d;
    int l;

    vecs[0] = '{8'hB2, 4'd8,  8, 8'hB2};
    vecs[1] = '{8'hA5, 4'd3,  3, 8'h05};
    vecs[2] = '{8'hA5, 4'd0,  8, 8'hA5};
    vecs[3] = '{8'h3C, 4'd12, 8, 8'h3C};
    vecs[4] = '{8'h01, 4'd1,  1, 8'h01};
    vecs[5] = '{8'h5A, 4'd5,  5, 8'h1A};
    vecs[6] = '{8'hFF, 4'd9,  8, 8'hFF};

    rst = 1'b1; start = 1'b0; data = '0; len = '0; hist = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'(obs()), 32'(pk(ST_IDLE, 1'b1, 1'b0, 1'b0, 1'b0)));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Held start: frames must be spaced L+GAP_CYC+1 = 6 cycles apart.
    wait_ready();
    data = 8'hA5; len = 4'd3; start = 1'b1;
    prev = state;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (state == 3'd1 && prev != 3'd1) starts.push_back(i);
      prev = state;
    end
    start = 1'b0;
    check("burst_count", 32'(starts.size()), 7);
    if (starts.size() > 0) check("burst_first", 32'(starts[0]), 1);
    for (int j = 1; j < starts.size(); j++)
      check($sformatf("burst_gap%0d", j), 32'(starts[j] - starts[j-1]), 6);

    // Reset on the 4th bit, with start raised alongside it.
    wait_ready();
    data = 8'hB2; len = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_bit4", 32'(obs()), 32'(pk(ST_SHIFT, 1'b0, 1'b1, 1'b1, 1'b0)));
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("mid_reset", 32'(obs()), 32'(pk(ST_IDLE, 1'b1, 1'b0, 1'b0, 1'b0)));
    rst = 1'b0;
    @(negedge clk);
    check("mid_restart", 32'(obs()), 32'(pk(ST_SHIFT, 1'b0, 1'b1, 1'b1, 1'b0)));
    start = 1'b0;
    wait_ready();

    // Loopback through the detector over random frames.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hist = '0;
    wait_ready();
    for (int f = 0; f < 25; f++) begin
      d = 8'($urandom);
      l = int'($urandom_range(1, 8));
      data = d; len = 4'(l); start = 1'b1;
      step(1'b0);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < l; k++) begin
        step(d[l-1-k]);
        @(negedge clk);
      end
      for (int g = 0; g < int'(GAP_CYC); g++) begin
        step(1'b0);
        @(negedge clk);
      end
      check($sformatf("lb_ready%0d", f), 32'(ready), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the maximum frame length in bits.
REQ-002 The module SHALL have parameter GAP_CYC, default 2, giving the idle cycles inserted after each frame (legal range 1..15).
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The module SHALL have port start, input, 1 bit: frame request, sampled at the rising edge of clk.
REQ-006 The module SHALL have port data, input, DATA_W bits: frame payload, captured on an accepted start.
REQ-007 The module SHALL have port len, input, 4 bits: frame length in bits; 0 means DATA_W; values above DATA_W clamp to DATA_W.
REQ-008 The module SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-009 The module SHALL have port serial_out, output, 1 bit: serial bit stream that feeds a sequence detector's 'in' input.
REQ-010 The module SHALL have port serial_valid, output, 1 bit: high while serial_out carries a payload bit.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse coincident with the last payload bit.
REQ-012 The module SHALL have port state, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-013 FSM states SHALL be IDLE=3'd0, SHIFT=3'd1, GAP=3'd2; codes 3..7 are illegal and SHALL go to IDLE on the next edge.
REQ-014 A start SHALL be accepted only when start=1 and ready=1 at the same edge; start in SHIFT or GAP SHALL be ignored, with no queuing.
REQ-015 On acceptance, the block SHALL capture data into the shift register, load the bit counter with the effective length L, and enter SHIFT at the next edge.
REQ-016 In SHIFT, the block SHALL drive the payload MSB-first starting at data[L-1], one bit per cycle, for exactly L cycles, with serial_valid=1 throughout.
REQ-017 The first payload bit SHALL appear on serial_out in the cycle directly after the accepting edge (latency 1 cycle).
REQ-018 done SHALL be 1 only during the cycle carrying bit data[0].
REQ-019 After the last bit, the block SHALL enter GAP for exactly GAP_CYC cycles with serial_out=0 and serial_valid=0, then return to IDLE.
REQ-020 In IDLE and GAP, serial_out SHALL be 0, serial_valid 0 and done 0.
REQ-021 The minimum frame-to-frame period SHALL be L+GAP_CYC+1 cycles.
REQ-022 All outputs SHALL be registered; no combinational path from start to serial_out.
REQ-023 Effective length rule: L = (len==0 || len>DATA_W) ? DATA_W : len. len=1 SHALL produce a single bit with done and serial_valid both high in the same cycle.

Reset
REQ-024 rst=1 at a clock edge SHALL force state=IDLE, ready=1, serial_out=0, serial_valid=0, done=0, and clear the shift register and counters.
REQ-025 A reset during SHIFT or GAP SHALL abort the frame immediately, with no further payload bits and no done pulse.
REQ-026 When rst and start are both 1 at the same edge, reset SHALL win and the start SHALL be dropped.

Structure
REQ-027 State encodings (IDLE/SHIFT/GAP) SHALL reside in a shared header/package serial_tx_pkg, so that detector benches decode state identically.
REQ-028 The block SHALL contain one sub-module, tx_shift_reg: a DATA_W-bit parallel-load, MSB-out, left-shifting register with load/shift enables; the FSM and counters stay in the top module.

Verification
REQ-029 The bench SHALL cover the following directed scenarios.
- Basic: rst 2 cycles, then start with data=8'b1011_0010, len=8 -> serial_out sequence 1,0,1,1,0,0,1,0 on cycles 1..8 after acceptance; done on cycle 8; ready returns on cycle 11 (GAP_CYC=2).
- Short/clamp: len=3 with data=8'hA5 -> bits 1,0,1 (data[2:0]); len=0 and len=12 each yield 8 bits.
- Single bit: len=1, data=8'h01 -> one cycle with serial_out=1, serial_valid=1, done=1.
- Ignored start: assert start continuously -> frames are spaced exactly L+3 cycles; no start is accepted during SHIFT or GAP.
- Reset mid-frame: rst=1 on the 4th bit of an 8-bit frame -> next cycle state=0, serial_valid=0, no done pulse; a new start is accepted on the first edge after rst=0.
- Loopback: drive serial_out into a Mealy detector -> its output matches a reference model over 25 frames of random data.
